// File: rtl/ddr5_cmd_sequencer_pkg.sv
// Shared declarations for the DDR5 command sequencer: command encoding, request fields
// and default DIMM timing values.
package ddr5_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    CmdNop  = 3'd0,
    CmdAct0 = 3'd1,
    CmdAct1 = 3'd2,
    CmdRd0  = 3'd3,
    CmdRd1  = 3'd4,
    CmdWr0  = 3'd5,
    CmdWr1  = 3'd6,
    CmdPre  = 3'd7
  } cmd_t;

  typedef struct packed {
    logic        channel;
    logic [2:0]  bank_group;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } mem_request_t;

  localparam int unsigned CntWidth = 10;

  localparam int unsigned DefTRcd   = 39;
  localparam int unsigned DefTRtp   = 18;
  localparam int unsigned DefTCwl   = 38;
  localparam int unsigned DefTBurst = 8;
  localparam int unsigned DefTWr    = 48;
  localparam int unsigned DefTRp    = 39;

endpackage

// File: rtl/ddr5_cmd_sequencer_dimm_tick_counter.sv
// DIMM tick generator (half CPU rate) plus a loadable down-counter that steps once per tick.
module ddr5_cmd_sequencer_dimm_tick_counter
  import ddr5_cmd_sequencer_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_value_i,
  output logic                tick_o,
  output logic                expire_o
);

  logic                phase_q;
  logic [CntWidth-1:0] count_q;

  // Decrement on the edge that closes the non-tick cycle, so the count is stable
  // throughout each tick period and saturates at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      count_q <= '0;
    end else begin
      phase_q <= ~phase_q;
      if (load_i) begin
        count_q <= load_value_i;
      end else if (phase_q && (count_q != '0)) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign tick_o   = ~phase_q;
  assign expire_o = (count_q == '0);

endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer: ACT0/ACT1, RD/WR pair, PRE per request with
// tRCD / tRTP / write-recovery / tRP spacing in DIMM ticks.
module ddr5_cmd_sequencer
  import ddr5_cmd_sequencer_pkg::*;
#(
  parameter int unsigned T_RCD   = DefTRcd,
  parameter int unsigned T_RTP   = DefTRtp,
  parameter int unsigned T_CWL   = DefTCwl,
  parameter int unsigned T_BURST = DefTBurst,
  parameter int unsigned T_WR    = DefTWr,
  parameter int unsigned T_RP    = DefTRp
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_operation,
  input  logic        req_channel,
  input  logic [2:0]  req_bank_group,
  input  logic [1:0]  req_bank,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output cmd_t        cmd_code,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bank_group,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic        done
);

  typedef enum logic [3:0] {
    StIdle, StAct0, StAct1, StWaitRcd, StCas0, StCas1, StWaitPre, StPre, StWaitRp
  } state_t;

  // Wait states are entered one tick after the issuing command, and their exit edge
  // schedules the following command one tick later, hence the -3 / -1 offsets.
  localparam logic [CntWidth-1:0] RcdLoad = CntWidth'(T_RCD - 3);
  localparam logic [CntWidth-1:0] RdPre   = CntWidth'(T_RTP);
  localparam logic [CntWidth-1:0] WrPre   = CntWidth'(T_CWL + T_BURST + T_WR);
  localparam logic [CntWidth-1:0] RpLoad  = CntWidth'(T_RP - 1);

  state_t              state_q;
  mem_request_t        req_q;
  mem_request_t        cmd_q;
  mem_request_t        req_in;
  logic                is_write_q;
  logic                cmd_valid_q;
  cmd_t                cmd_code_q;
  logic                done_q;
  logic                tick;
  logic                expire;
  logic                cnt_load;
  logic [CntWidth-1:0] cnt_value;
  logic [CntWidth-1:0] pre_delay;
  logic                accept;

  assign req_in = '{channel:    req_channel,
                    bank_group: req_bank_group,
                    bank:       req_bank,
                    row:        req_row,
                    col:        req_col};

  assign req_ready = (state_q == StIdle) && !reset;
  assign accept    = req_valid && req_ready;
  assign pre_delay = is_write_q ? WrPre : RdPre;

  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    if (!tick) begin
      case (state_q)
        StAct1: begin
          cnt_load  = 1'b1;
          cnt_value = RcdLoad;
        end
        StCas1: begin
          cnt_load  = 1'b1;
          cnt_value = pre_delay - CntWidth'(3);
        end
        StPre: begin
          cnt_load  = 1'b1;
          cnt_value = RpLoad;
        end
        default: ;
      endcase
    end
  end

  ddr5_cmd_sequencer_dimm_tick_counter u_tick_counter (
    .clk_i       (clock),
    .rst_i       (reset),
    .load_i      (cnt_load),
    .load_value_i(cnt_value),
    .tick_o      (tick),
    .expire_o    (expire)
  );

  // Commands are decided on the edge closing a non-tick cycle so the registered
  // outputs appear exactly in the tick cycle they are scheduled for.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      req_q       <= '0;
      cmd_q       <= '0;
      is_write_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CmdNop;
      done_q      <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CmdNop;
      done_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            req_q      <= req_in;
            is_write_q <= (req_operation == 2'd1);
            if (!tick) begin
              cmd_valid_q <= 1'b1;
              cmd_code_q  <= CmdAct0;
              cmd_q       <= req_in;
              state_q     <= StAct1;
            end else begin
              state_q <= StAct0;
            end
          end
        end
        StAct0: begin
          if (!tick) begin
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= CmdAct0;
            cmd_q       <= req_q;
            state_q     <= StAct1;
          end
        end
        StAct1: begin
          if (!tick) begin
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= CmdAct1;
            cmd_q       <= req_q;
            state_q     <= (T_RCD == 2) ? StCas0 : StWaitRcd;
          end
        end
        StWaitRcd: begin
          if (!tick && expire) state_q <= StCas0;
        end
        StCas0: begin
          if (!tick) begin
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= is_write_q ? CmdWr0 : CmdRd0;
            cmd_q       <= req_q;
            state_q     <= StCas1;
          end
        end
        StCas1: begin
          if (!tick) begin
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= is_write_q ? CmdWr1 : CmdRd1;
            cmd_q       <= req_q;
            state_q     <= (pre_delay == CntWidth'(2)) ? StPre : StWaitPre;
          end
        end
        StWaitPre: begin
          if (!tick && expire) state_q <= StPre;
        end
        StPre: begin
          if (!tick) begin
            cmd_valid_q <= 1'b1;
            cmd_code_q  <= CmdPre;
            cmd_q       <= req_q;
            state_q     <= StWaitRp;
          end
        end
        StWaitRp: begin
          // Stay here through the done cycle so req_ready rises only afterwards.
          if (done_q) begin
            state_q <= StIdle;
          end else if (!tick && expire) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_valid      = cmd_valid_q;
  assign cmd_code       = cmd_code_q;
  assign done           = done_q;
  assign cmd_channel    = cmd_q.channel;
  assign cmd_bank_group = cmd_q.bank_group;
  assign cmd_bank       = cmd_q.bank;
  assign cmd_row        = cmd_q.row;
  assign cmd_col        = cmd_q.col;

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer with default timing; cycle numbers count from
// the first cycle after reset deassertion.
module tb_ddr5_cmd_sequencer;
  import ddr5_cmd_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_operation = 2'd0;
  logic        req_channel = 1'b0;
  logic [2:0]  req_bank_group = 3'd0;
  logic [1:0]  req_bank = 2'd0;
  logic [15:0] req_row = 16'd0;
  logic [9:0]  req_col = 10'd0;
  logic        cmd_valid;
  cmd_t        cmd_code;
  logic        cmd_channel;
  logic [2:0]  cmd_bank_group;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int ncmd = 0;
  int ndone = 0;
  int odd_issue = 0;

  ddr5_cmd_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_operation (req_operation),
    .req_channel   (req_channel),
    .req_bank_group(req_bank_group),
    .req_bank      (req_bank),
    .req_row       (req_row),
    .req_col       (req_col),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_channel   (cmd_channel),
    .cmd_bank_group(cmd_bank_group),
    .cmd_bank      (cmd_bank),
    .cmd_row       (cmd_row),
    .cmd_col       (cmd_col),
    .done          (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (cmd_valid === 1'b1) begin
      ncmd <= ncmd + 1;
      if (cyc[0]) odd_issue <= odd_issue + 1;
    end
    if (done === 1'b1) ndone <= ndone + 1;
  end

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic ch, input logic [2:0] bg,
                       input logic [1:0] bk, input logic [15:0] row, input logic [9:0] col);
    req_operation  = op;
    req_channel    = ch;
    req_bank_group = bg;
    req_bank       = bk;
    req_row        = row;
    req_col        = col;
    req_valid      = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    @(negedge clock); #1;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic expect_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cmd(input string tag, input logic v, input cmd_t code);
    checks++;
    assert ({cmd_valid, cmd_code} === {v, code}) else begin
      errors++;
      $error("FAIL %s observed valid=%b code=%0d expected valid=%b code=%0d",
             tag, cmd_valid, cmd_code, v, code);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cmd;
    int base_done;

    // Reset values while reset is held.
    reset = 1'b1;
    @(negedge clock); #1;
    expect_bit("rst_ready", req_ready, 1'b0);
    expect_cmd("rst_cmd", 1'b0, CmdNop);
    expect_val("rst_fields", {cmd_channel, cmd_bank_group, cmd_bank, cmd_row, cmd_col}, 32'h0);
    expect_bit("rst_done", done, 1'b0);
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    expect_bit("ready_c0", req_ready, 1'b1);
    step_to(1);
    expect_cmd("idle_c1", 1'b0, CmdNop);

    // Scenario 1: read accepted on non-tick cycle 1.
    base_cmd = ncmd;
    drive(2'd0, 1'b0, 3'd1, 2'd3, 16'h1234, 10'h055);
    step_to(2);
    req_valid = 1'b0;
    expect_cmd("s1_act0", 1'b1, CmdAct0);
    expect_bit("s1_ready_busy", req_ready, 1'b0);
    expect_val("s1_row", 32'(cmd_row), 32'h1234);
    step_to(3);
    expect_cmd("s1_gap", 1'b0, CmdNop);
    expect_val("s1_row_hold", 32'(cmd_row), 32'h1234);
    step_to(4);   expect_cmd("s1_act1", 1'b1, CmdAct1);
    step_to(80);  expect_cmd("s1_rd0", 1'b1, CmdRd0);
    expect_val("s1_col", 32'(cmd_col), 32'h055);
    step_to(82);  expect_cmd("s1_rd1", 1'b1, CmdRd1);
    step_to(116); expect_cmd("s1_pre", 1'b1, CmdPre);
    step_to(194);
    expect_cmd("s1_done_nocmd", 1'b0, CmdNop);
    expect_bit("s1_done", done, 1'b1);
    expect_bit("s1_ready_194", req_ready, 1'b0);
    step_to(195);
    expect_bit("s1_ready_195", req_ready, 1'b1);
    expect_bit("s1_done_195", done, 1'b0);
    expect_val("s1_ncmd", 32'(ncmd - base_cmd), 32'd5);

    // Scenario 2: write accepted on cycle 1.
    do_reset();
    step_to(1);
    drive(2'd1, 1'b0, 3'd2, 2'd1, 16'h4321, 10'h2AA);
    step_to(2);
    req_valid = 1'b0;
    expect_cmd("s2_act0", 1'b1, CmdAct0);
    step_to(4);   expect_cmd("s2_act1", 1'b1, CmdAct1);
    step_to(80);  expect_cmd("s2_wr0", 1'b1, CmdWr0);
    step_to(82);  expect_cmd("s2_wr1", 1'b1, CmdWr1);
    step_to(116); expect_cmd("s2_no_early_pre", 1'b0, CmdNop);
    step_to(268); expect_cmd("s2_pre", 1'b1, CmdPre);
    step_to(346); expect_bit("s2_done", done, 1'b1);
    step_to(347); expect_bit("s2_ready", req_ready, 1'b1);

    // Scenario 3: accepted on tick cycle 0, field propagation.
    do_reset();
    drive(2'd0, 1'b1, 3'd5, 2'd2, 16'hBEEF, 10'h3A5);
    step_to(1);
    req_valid = 1'b0;
    expect_cmd("s3_c1_quiet", 1'b0, CmdNop);
    step_to(2);
    expect_cmd("s3_act0", 1'b1, CmdAct0);
    expect_val("s3_row", 32'(cmd_row), 32'hBEEF);
    expect_val("s3_bg", 32'(cmd_bank_group), 32'd5);
    expect_val("s3_bank", 32'(cmd_bank), 32'd2);
    expect_val("s3_col", 32'(cmd_col), 32'h3A5);
    expect_bit("s3_channel", cmd_channel, 1'b1);
    step_to(80); expect_cmd("s3_rd0", 1'b1, CmdRd0);

    // Scenario 4: ifetch behaves as a read; req_valid toggling while busy is ignored.
    do_reset();
    step_to(1);
    drive(2'd2, 1'b0, 3'd3, 2'd1, 16'h0F0F, 10'h111);
    step_to(2);
    req_valid = 1'b0;
    base_cmd = ncmd;
    req_operation = 2'd1;
    req_row = 16'hDEAD;
    for (int i = 10; i < 40; i++) begin
      step_to(i);
      req_valid = ~req_valid;
    end
    req_valid = 1'b0;
    step_to(80);
    expect_cmd("s4_rd0", 1'b1, CmdRd0);
    expect_val("s4_row", 32'(cmd_row), 32'h0F0F);
    step_to(82);  expect_cmd("s4_rd1", 1'b1, CmdRd1);
    step_to(116); expect_cmd("s4_pre", 1'b1, CmdPre);
    step_to(194); expect_bit("s4_done", done, 1'b1);
    expect_val("s4_ncmd", 32'(ncmd - base_cmd), 32'd4);

    // Scenario 5: back-to-back requests with req_valid held high.
    do_reset();
    base_cmd = ncmd;
    base_done = ndone;
    step_to(1);
    drive(2'd0, 1'b0, 3'd0, 2'd0, 16'h1111, 10'h001);
    step_to(2);
    expect_cmd("s5_a_act0", 1'b1, CmdAct0);
    drive(2'd1, 1'b1, 3'd7, 2'd3, 16'h2222, 10'h3FF);
    step_to(194);
    expect_bit("s5_a_done", done, 1'b1);
    expect_cmd("s5_a_done_nocmd", 1'b0, CmdNop);
    step_to(195);
    expect_bit("s5_ready", req_ready, 1'b1);
    step_to(196);
    req_valid = 1'b0;
    expect_cmd("s5_b_act0", 1'b1, CmdAct0);
    expect_val("s5_b_row", 32'(cmd_row), 32'h2222);
    expect_val("s5_ncmd_a", 32'(ncmd - base_cmd), 32'd6);
    step_to(274);
    expect_cmd("s5_b_wr0", 1'b1, CmdWr0);
    expect_val("s5_b_col", 32'(cmd_col), 32'h3FF);
    step_to(462); expect_cmd("s5_b_pre", 1'b1, CmdPre);
    step_to(540); expect_bit("s5_b_done", done, 1'b1);
    step_to(600);
    expect_bit("s5_idle_ready", req_ready, 1'b1);
    expect_val("s5_ncmd_total", 32'(ncmd - base_cmd), 32'd10);
    expect_val("s5_ndone", 32'(ndone - base_done), 32'd2);

    // Scenario 6: reset during WAIT_PRE drops the request.
    do_reset();
    step_to(1);
    drive(2'd0, 1'b1, 3'd4, 2'd1, 16'h5A5A, 10'h0AA);
    step_to(2);
    req_valid = 1'b0;
    step_to(90);
    expect_cmd("s6_waitpre", 1'b0, CmdNop);
    base_cmd = ncmd;
    base_done = ndone;
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    #1;
    expect_cmd("s6_rst_cmd", 1'b0, CmdNop);
    expect_bit("s6_rst_done", done, 1'b0);
    expect_bit("s6_rst_ready", req_ready, 1'b1);
    expect_val("s6_rst_row", 32'(cmd_row), 32'h0);
    step_to(1);
    drive(2'd0, 1'b0, 3'd6, 2'd2, 16'h6B6B, 10'h155);
    step_to(2);
    req_valid = 1'b0;
    expect_cmd("s6_act0", 1'b1, CmdAct0);
    expect_val("s6_row", 32'(cmd_row), 32'h6B6B);
    expect_val("s6_no_stale", 32'(ncmd - base_cmd), 32'd1);
    step_to(80);  expect_cmd("s6_rd0", 1'b1, CmdRd0);
    step_to(116); expect_cmd("s6_pre", 1'b1, CmdPre);
    step_to(194); expect_bit("s6_done", done, 1'b1);
    step_to(196);
    expect_val("s6_ndone", 32'(ndone - base_done), 32'd1);

    expect_val("tick_only_issue", 32'(odd_issue), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
